// File: rtl/dpsk_frame_sync.sv
// DPSK differential bit decoder with sync-word framing: hunts for SYNC_WORD,
// emits PAYLOAD_LEN bytes per frame, and flywheels through up to MAX_MISS-1 sync misses.
module dpsk_frame_sync #(
  parameter logic [15:0] SYNC_WORD   = 16'hEB90,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned MAX_MISS    = 2
) (
  input  logic       clk1,
  input  logic       rst_n_i,
  input  logic       data_i,
  input  logic       syn_i,
  output logic       bit_o,
  output logic       bit_vld_o,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       locked_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, SYNC} state_t;

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_LEN - 1);
  localparam logic [3:0] MISS_LIM  = 4'(MAX_MISS);

  state_t      state;
  logic        syn_q;
  logic        prev_s;
  logic [15:0] shreg;
  logic [3:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [3:0]  miss_cnt;

  logic        strobe;
  logic        d;
  logic [15:0] shreg_nxt;
  logic [3:0]  miss_inc;

  assign strobe    = syn_i & ~syn_q;
  assign d         = data_i ^ prev_s;
  assign shreg_nxt = {shreg[14:0], d};
  assign miss_inc  = miss_cnt + 4'd1;

  always_ff @(posedge clk1) begin
    if (!rst_n_i) begin
      state       <= HUNT;
      syn_q       <= 1'b0;
      prev_s      <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      miss_cnt    <= '0;
      bit_o       <= 1'b0;
      bit_vld_o   <= 1'b0;
      byte_o      <= '0;
      byte_vld_o  <= 1'b0;
      locked_o    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      syn_q       <= syn_i;
      bit_o       <= 1'b0;
      bit_vld_o   <= 1'b0;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (strobe) begin
        prev_s    <= data_i;
        shreg     <= shreg_nxt;
        bit_o     <= d;
        bit_vld_o <= 1'b1;
        case (state)
          HUNT: begin
            if (shreg_nxt == SYNC_WORD) begin
              state    <= PAYLOAD;
              locked_o <= 1'b1;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          PAYLOAD: begin
            // The low byte of the shared shift register is the assembled byte.
            if (bit_cnt == 4'd7) begin
              byte_o     <= shreg_nxt[7:0];
              byte_vld_o <= 1'b1;
              bit_cnt    <= '0;
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                state    <= SYNC;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          SYNC: begin
            if (bit_cnt == 4'd15) begin
              bit_cnt <= '0;
              if (shreg_nxt == SYNC_WORD) begin
                state    <= PAYLOAD;
                miss_cnt <= '0;
              end else begin
                frame_err_o <= 1'b1;
                miss_cnt    <= miss_inc;
                if (miss_inc == MISS_LIM) begin
                  state    <= HUNT;
                  locked_o <= 1'b0;
                end else begin
                  state <= PAYLOAD;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpsk_frame_sync.sv
// Self-checking bench for dpsk_frame_sync: expected payload bytes are queued as
// stimulus is driven and popped when the DUT strobes byte_vld_o.
module tb_dpsk_frame_sync;

  logic       clk1;
  logic       rst_n_i;
  logic       data_i;
  logic       syn_i;
  logic       bit_o;
  logic       bit_vld_o;
  logic [7:0] byte_o;
  logic       byte_vld_o;
  logic       locked_o;
  logic       frame_err_o;

  int         checks;
  int         errors;
  int         ferr_cnt;
  logic       prev_lvl;
  logic [7:0] exp_q[$];

  dpsk_frame_sync #(
    .SYNC_WORD  (16'hEB90),
    .PAYLOAD_LEN(4),
    .MAX_MISS   (2)
  ) dut (
    .clk1       (clk1),
    .rst_n_i    (rst_n_i),
    .data_i     (data_i),
    .syn_i      (syn_i),
    .bit_o      (bit_o),
    .bit_vld_o  (bit_vld_o),
    .byte_o     (byte_o),
    .byte_vld_o (byte_vld_o),
    .locked_o   (locked_o),
    .frame_err_o(frame_err_o)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk1);
    rst_n_i = 1'b0;
    syn_i   = 1'b0;
    data_i  = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    rst_n_i  = 1'b1;
    prev_lvl = 1'b0;
    ferr_cnt = 0;
  endtask

  // One strobe: idle cycle with syn_i low, then one cycle with syn_i high.
  task automatic send_level(input logic lvl, input logic exp_d);
    logic [7:0] exp_b;
    @(negedge clk1);
    checks++;
    if (bit_vld_o !== 1'b0 || byte_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobes bit_vld=%b byte_vld=%b required 0 0", bit_vld_o, byte_vld_o);
    end
    data_i = lvl;
    syn_i  = 1'b1;
    @(negedge clk1);
    checks++;
    if (bit_vld_o !== 1'b1 || bit_o !== exp_d) begin
      errors++;
      $display("FAIL bit_out vld=%b bit=%b required 1 %b", bit_vld_o, bit_o, exp_d);
    end
    if (byte_vld_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got %02h required none", byte_o);
      end else begin
        exp_b = exp_q.pop_front();
        if (byte_o !== exp_b) begin
          errors++;
          $display("FAIL byte_value got %02h required %02h", byte_o, exp_b);
        end
      end
    end
    if (frame_err_o === 1'b1) ferr_cnt++;
    syn_i = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    logic lvl;
    lvl      = prev_lvl ^ b;
    prev_lvl = lvl;
    send_level(lvl, b);
  endtask

  task automatic send_word16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    syn_i   = 1'b0;
    data_i  = 1'b0;
    repeat (2) @(negedge clk1);
    checks++;
    if ({bit_o, bit_vld_o, byte_o, byte_vld_o, locked_o, frame_err_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {bit_o, bit_vld_o, byte_o, byte_vld_o, locked_o, frame_err_o});
    end
    syn_i  = 1'b1;
    data_i = 1'b1;
    @(negedge clk1);
    checks++;
    if (bit_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority bit_vld=%b required 0", bit_vld_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk1);
    checks++;
    if (bit_vld_o !== 1'b1 || bit_o !== 1'b1) begin
      errors++;
      $display("FAIL first_strobe_after_reset vld=%b bit=%b required 1 1", bit_vld_o, bit_o);
    end
    syn_i = 1'b0;
    do_reset();
  endtask

  task automatic test_diff_decode;
    do_reset();
    send_level(1'b0, 1'b0);
    send_level(1'b1, 1'b1);
    send_level(1'b1, 1'b0);
    send_level(1'b0, 1'b1);
  endtask

  task automatic test_lock_frames;
    logic [15:0] sw;
    do_reset();
    sw = 16'hEB90;
    for (int i = 15; i >= 1; i--) send_bit(sw[i]);
    checks++;
    if (locked_o !== 1'b0) begin
      errors++;
      $display("FAIL early_lock locked=%b required 0", locked_o);
    end
    send_bit(sw[0]);
    checks++;
    if (locked_o !== 1'b1) begin
      errors++;
      $display("FAIL lock_on_16th locked=%b required 1", locked_o);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_word16(16'hEB90);
    checks++;
    if (ferr_cnt != 0 || locked_o !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sync_match ferr=%0d locked=%b pending=%0d required 0 1 0", ferr_cnt, locked_o, exp_q.size());
    end
    send_byte(8'h9A);
    send_byte(8'hBC);
    send_byte(8'hDE);
    send_byte(8'hF0);
    send_word16(16'hEB91);
    checks++;
    if (ferr_cnt != 1 || locked_o !== 1'b1) begin
      errors++;
      $display("FAIL first_miss ferr=%0d locked=%b required 1 1", ferr_cnt, locked_o);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL flywheel_bytes pending=%0d required 0", exp_q.size());
    end
    send_word16(16'h0000);
    checks++;
    if (ferr_cnt != 2 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL second_miss ferr=%0d locked=%b required 2 0", ferr_cnt, locked_o);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b0);
  endtask

  task automatic test_offset_lock;
    logic [15:0] sw;
    logic [2:0]  junk;
    do_reset();
    junk = 3'($urandom_range(0, 7));
    for (int i = 2; i >= 0; i--) send_bit(junk[i]);
    sw = 16'hEB90;
    for (int i = 15; i >= 1; i--) send_bit(sw[i]);
    checks++;
    if (locked_o !== 1'b0) begin
      errors++;
      $display("FAIL offset_early_lock locked=%b required 0", locked_o);
    end
    send_bit(sw[0]);
    checks++;
    if (locked_o !== 1'b1) begin
      errors++;
      $display("FAIL offset_lock locked=%b required 1", locked_o);
    end
    send_byte(8'hA5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL offset_byte pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] part;
    do_reset();
    send_word16(16'hEB90);
    send_byte(8'h5A);
    part = 8'hC3;
    for (int i = 7; i >= 3; i--) send_bit(part[i]);
    @(negedge clk1);
    rst_n_i = 1'b0;
    @(negedge clk1);
    checks++;
    if ({bit_o, bit_vld_o, byte_o, byte_vld_o, locked_o, frame_err_o} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b required 0", {bit_o, bit_vld_o, byte_o, byte_vld_o, locked_o, frame_err_o});
    end
    rst_n_i  = 1'b1;
    prev_lvl = 1'b0;
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    checks++;
    if (locked_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hunt locked=%b required 0", locked_o);
    end
    send_word16(16'hEB90);
    send_byte(8'h69);
    checks++;
    if (locked_o !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL relock locked=%b pending=%0d required 1 0", locked_o, exp_q.size());
    end
  endtask

  task automatic test_stuck_syn;
    logic [7:0] b;
    do_reset();
    send_word16(16'hEB90);
    b = 8'h35;
    exp_q.push_back(b);
    @(negedge clk1);
    data_i = prev_lvl;
    syn_i  = 1'b1;
    @(negedge clk1);
    checks++;
    if (bit_vld_o !== 1'b1 || bit_o !== b[7]) begin
      errors++;
      $display("FAIL stuck_entry vld=%b bit=%b required 1 %b", bit_vld_o, bit_o, b[7]);
    end
    for (int i = 0; i < 1000; i++) begin
      data_i = ~data_i;
      @(negedge clk1);
      checks++;
      if (bit_vld_o !== 1'b0 || byte_vld_o !== 1'b0 || locked_o !== 1'b1) begin
        errors++;
        $display("FAIL stuck_hold cycle=%0d vld=%b byte_vld=%b locked=%b required 0 0 1", i, bit_vld_o, byte_vld_o, locked_o);
      end
    end
    syn_i  = 1'b0;
    data_i = prev_lvl;
    for (int i = 6; i >= 0; i--) send_bit(b[i]);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stuck_resume pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ferr_cnt = 0;
    prev_lvl = 1'b0;
    rst_n_i  = 1'b0;
    syn_i    = 1'b0;
    data_i   = 1'b0;
    test_reset();
    test_diff_decode();
    test_lock_frames();
    test_offset_lock();
    test_mid_reset();
    test_stuck_syn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpsk_frame_sync.md
DPSK_FRAME_SYNC -- requirements
Module: dpsk_frame_sync

Interface
REQ-001 Parameter SYNC_WORD, default 16'hEB90: frame sync pattern, MSB first, SHALL be nonzero.
REQ-002 Parameter PAYLOAD_LEN, default 4: payload bytes per frame, range 1..255.
REQ-003 Parameter MAX_MISS, default 2: consecutive sync misses before lock loss, range 1..15.
REQ-004 clk1  input  1  system clock, the same clock driving the DPLL.
REQ-005 rst_n_i  input  1  synchronous, active-low reset.
REQ-006 data_i  input  1  received DPSK baseband level.
REQ-007 syn_i  input  1  recovered bit clock from the DPLL, synchronous to clk1.
REQ-008 bit_o  output  1  differentially decoded bit.
REQ-009 bit_vld_o  output  1  one-cycle strobe qualifying bit_o.
REQ-010 byte_o  output  8  payload byte, MSB first as received.
REQ-011 byte_vld_o  output  1  one-cycle strobe qualifying byte_o.
REQ-012 locked_o  output  1  high while frame-locked.
REQ-013 frame_err_o  output  1  one-cycle pulse on a sync-word mismatch while locked.

Function
REQ-014 The block SHALL register syn_i into syn_q and define strobe = syn_i & ~syn_q (rising edge) in cycle t.
REQ-015 On strobe it SHALL sample s = data_i, compute d = s XOR prev_s, then update prev_s <= s.
REQ-016 bit_o SHALL equal d with bit_vld_o high for exactly cycle t+1; both are 0 otherwise.
REQ-017 All state, counters, the shift register and the other outputs SHALL update only at the clock edge ending a strobe cycle, so results are visible at t+1.
REQ-018 The 16-bit shift register SHALL shift d in at the LSB on every strobe, in every state.
REQ-019 The FSM SHALL have states HUNT, PAYLOAD and SYNC.
REQ-020 HUNT: the post-shift register SHALL be compared on every bit (sliding); on a match the FSM SHALL go to PAYLOAD, set locked_o=1, and clear bit_cnt, byte_cnt and miss_cnt.
REQ-021 PAYLOAD: the block SHALL assemble bytes MSB first.
REQ-022 PAYLOAD: on the 8th bit, byte_o SHALL load the byte and byte_vld_o SHALL pulse in the same cycle as that bit's bit_vld_o.
REQ-023 PAYLOAD: after byte PAYLOAD_LEN the FSM SHALL go to SYNC with bit_cnt=0.
REQ-024 SYNC: on the 16th bit the post-shift register SHALL be compared with SYNC_WORD.
REQ-025 SYNC match: the FSM SHALL go to PAYLOAD and set miss_cnt=0.
REQ-026 SYNC mismatch: frame_err_o SHALL pulse and miss_cnt SHALL increment.
REQ-027 After a mismatch, if the new miss_cnt equals MAX_MISS the FSM SHALL go to HUNT with locked_o=0; otherwise it SHALL go to PAYLOAD (flywheel) with locked_o held at 1.
REQ-028 byte_vld_o SHALL never assert outside PAYLOAD, and no partial byte SHALL ever be emitted.
REQ-029 If syn_i is stuck at either level, the block SHALL produce no strobes and all state SHALL hold.
REQ-030 syn_i high in the first cycle after reset SHALL count as a strobe only if syn_q=0 (syn_q resets to 0).

Reset
REQ-031 When rst_n_i=0 at a clock edge, the block SHALL set state=HUNT, and syn_q, prev_s, the shift register, bit_cnt, byte_cnt and miss_cnt SHALL be 0.
REQ-032 In the same reset condition, bit_o, bit_vld_o, byte_o=8'h00, byte_vld_o, locked_o and frame_err_o SHALL be 0.
REQ-033 Reset SHALL take priority over a coincident strobe.
REQ-034 Reset mid-frame SHALL discard the partial byte and lock, with no output pulse.

Verification
REQ-035 Strobes with levels 0,1,1,0 after reset -> bit_o=0,1,0,1, each bit_vld_o one cycle after its strobe.
REQ-036 Decoded stream 0xEB90, 0x12,0x34,0x56,0x78 -> locked_o=1 after the 16th bit; byte_o=12,34,56,78 with 4 byte_vld_o pulses; FSM in SYNC afterwards.
REQ-037 Continue REQ-036 with 0xEB91 then 4 bytes, then 0x0000 -> frame_err_o pulses twice; locked_o drops on the second miss; the first flywheel frame's bytes are still output.
REQ-038 Sync word embedded at bit offset 3 after random bits in HUNT -> lock on the exact 16th sync bit; the first byte is aligned correctly.
REQ-039 rst_n_i=0 for one cycle after the 5th payload bit of byte 2 -> all outputs 0, HUNT, no byte_vld_o until a fresh sync word.
REQ-040 syn_i held high for 1000 cycles while data_i toggles -> no bit_vld_o, byte_vld_o or state change.
